// File: rtl/rf_pkg.sv
// Shared defaults and the queued write-back entry record for the register-file write-back buffer.
package rf_pkg;
  localparam int BW_DATA_DEF  = 32;
  localparam int BW_ADDR_DEF  = 5;
  localparam int DEPTH_DEF    = 4;
  localparam int ZERO_REG_DEF = 1;

  typedef struct packed {
    logic [BW_ADDR_DEF-1:0] addr;
    logic [BW_DATA_DEF-1:0] data;
  } rf_entry_t;
endpackage

// File: rtl/rf_wb_lookup.sv
// Newest-first match of one lookup address against the occupied FIFO entries.
// Purely combinational; no handshake.
module rf_wb_lookup
  import rf_pkg::*;
#(
  parameter int BW_DATA  = BW_DATA_DEF,
  parameter int BW_ADDR  = BW_ADDR_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic [DEPTH-1:0][BW_ADDR-1:0] ent_addr,
  input  logic [DEPTH-1:0][BW_DATA-1:0] ent_data,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [$clog2(DEPTH):0]        count,
  input  logic [BW_ADDR-1:0]            lk_addr,
  output logic                          hit,
  output logic [BW_DATA-1:0]            data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;
  logic          lk_ok;

  assign lk_ok = !(ZERO_REG != 0 && lk_addr == '0);

  // Walk oldest to newest so the last match (the newest) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (lk_ok && (CW'(i) < count) && (ent_addr[idx] == lk_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/rf_wb_buffer.sv
// Write-back FIFO feeding the regfile write port with newest-first forwarding lookups.
// Accept-to-write latency 1 cycle; o_wb_ready low when full; i_wr_stall holds the drain.
module rf_wb_buffer
  import rf_pkg::*;
#(
  parameter int BW_DATA  = BW_DATA_DEF,
  parameter int BW_ADDR  = BW_ADDR_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wb_valid,
  output logic                     o_wb_ready,
  input  logic [BW_ADDR-1:0]       i_wb_addr,
  input  logic [BW_DATA-1:0]       i_wb_data,
  output logic                     o_wr_en,
  output logic [BW_ADDR-1:0]       o_wr_addr,
  output logic [BW_DATA-1:0]       o_wr_data,
  input  logic                     i_wr_stall,
  input  logic [BW_ADDR-1:0]       i_lk_addr0,
  input  logic [BW_ADDR-1:0]       i_lk_addr1,
  output logic                     o_lk_hit0,
  output logic                     o_lk_hit1,
  output logic [BW_DATA-1:0]       o_lk_data0,
  output logic [BW_DATA-1:0]       o_lk_data1,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][BW_ADDR-1:0] mem_addr;
  logic [DEPTH-1:0][BW_DATA-1:0] mem_data;
  logic [PW-1:0]                 head_q;
  logic [PW-1:0]                 tail_q;
  logic [CW-1:0]                 count_q;
  logic                          accept;
  logic                          push;
  logic                          pop;

  assign o_wb_ready = !i_rst && (count_q < CW'(DEPTH));
  assign accept     = i_wb_valid && o_wb_ready;
  // Writes to the hard-wired zero register complete the handshake but are never queued.
  assign push       = accept && !(ZERO_REG != 0 && i_wb_addr == '0);
  assign o_empty    = (count_q == '0);
  assign o_wr_en    = !i_rst && !o_empty && !i_wr_stall;
  assign pop        = o_wr_en;
  assign o_wr_addr  = o_empty ? '0 : mem_addr[head_q];
  assign o_wr_data  = o_empty ? '0 : mem_data[head_q];
  assign o_count    = count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only occupied slots are ever observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[tail_q] <= i_wb_addr;
      mem_data[tail_q] <= i_wb_data;
    end
  end

  rf_wb_lookup #(
    .BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_lookup0 (
    .ent_addr(mem_addr), .ent_data(mem_data), .head(head_q), .count(count_q),
    .lk_addr(i_lk_addr0), .hit(o_lk_hit0), .data(o_lk_data0)
  );

  rf_wb_lookup #(
    .BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
  ) u_lookup1 (
    .ent_addr(mem_addr), .ent_data(mem_data), .head(head_q), .count(count_q),
    .lk_addr(i_lk_addr1), .hit(o_lk_hit1), .data(o_lk_data1)
  );
endmodule

// File: tb/tb_rf_wb_buffer.sv
// Bench for rf_wb_buffer: queue-based reference model plus a behavioural regfile fed by the write port.
module tb_rf_wb_buffer;
  import rf_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic        i_clk;
  logic        i_rst;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        i_wr_stall;
  logic [4:0]  i_lk_addr0;
  logic [4:0]  i_lk_addr1;
  logic        o_lk_hit0;
  logic        o_lk_hit1;
  logic [31:0] o_lk_data0;
  logic [31:0] o_lk_data1;
  logic [2:0]  o_count;
  logic        o_empty;

  rf_wb_buffer #(.BW_DATA(32), .BW_ADDR(5), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_stall(i_wr_stall),
    .i_lk_addr0(i_lk_addr0), .i_lk_addr1(i_lk_addr1),
    .o_lk_hit0(o_lk_hit0), .o_lk_hit1(o_lk_hit1),
    .o_lk_data0(o_lk_data0), .o_lk_data1(o_lk_data1),
    .o_count(o_count), .o_empty(o_empty)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks;
  int failures;

  rf_entry_t   mq[$];
  logic [31:0] rf_model[32];
  logic [31:0] rf_arr[32];

  // Stand-in for the downstream register file array.
  always @(posedge i_clk) if (o_wr_en) rf_arr[o_wr_addr] <= o_wr_data;

  logic        e_ready, e_wr_en, e_empty, e_hit0, e_hit1;
  logic [4:0]  e_addr;
  logic [31:0] e_data, e_d0, e_d1;
  logic [2:0]  e_count;

  function automatic logic [32:0] model_lookup(input logic [4:0] la);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (la != 5'd0 && mq[i].addr == la) return {1'b1, mq[i].data};
    return 33'd0;
  endfunction

  function automatic void model_expect();
    logic [32:0] r0, r1;
    e_ready = !i_rst && (mq.size() < DEPTH);
    e_empty = (mq.size() == 0);
    e_wr_en = !i_rst && !e_empty && !i_wr_stall;
    e_addr  = e_empty ? 5'd0 : mq[0].addr;
    e_data  = e_empty ? 32'd0 : mq[0].data;
    e_count = 3'(mq.size());
    r0 = model_lookup(i_lk_addr0);
    r1 = model_lookup(i_lk_addr1);
    {e_hit0, e_d0} = r0;
    {e_hit1, e_d1} = r1;
  endfunction

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic st, input logic [4:0] l0, input logic [4:0] l1,
                       input logic rst);
    i_wb_valid = v; i_wb_addr = a; i_wb_data = d; i_wr_stall = st;
    i_lk_addr0 = l0; i_lk_addr1 = l1; i_rst = rst;
    #1;
    model_expect();
  endtask

  task automatic tick();
    rf_entry_t e;
    @(posedge i_clk);
    if (i_rst) mq.delete();
    else begin
      if (e_wr_en) begin
        rf_model[mq[0].addr] = mq[0].data;
        void'(mq.pop_front());
      end
      if (i_wb_valid && e_ready && i_wb_addr != 5'd0) begin
        e.addr = i_wb_addr; e.data = i_wb_data;
        mq.push_back(e);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (o_wb_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_in_reset got=%b exp=0", o_wb_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (o_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", o_wr_en); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", o_count); end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", o_empty); end
    checks++; if ({o_wr_addr, o_wr_data} !== 37'd0) begin failures++; $display("FAIL rst_wr_bus got=%h exp=0", {o_wr_addr, o_wr_data}); end
    checks++; if ({o_lk_hit0, o_lk_data0, o_lk_hit1, o_lk_data1} !== 66'd0) begin failures++; $display("FAIL rst_lookup got=%h exp=0", {o_lk_hit0, o_lk_data0, o_lk_hit1, o_lk_data1}); end
    checks++; if (o_wb_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", o_wb_ready); end
    tick();
  endtask

  task automatic test_single_write();
    drive(1, 5, 32'hDEADBEEF, 0, 5, 0, 0);
    checks++; if (o_lk_hit0 !== 1'b0) begin failures++; $display("FAIL single_offer_no_hit got=%b exp=0", o_lk_hit0); end
    tick();
    drive(0, 0, 0, 0, 5, 0, 0);
    checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin failures++; $display("FAIL single_wr got=%h exp=%h", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 5'd5, 32'hDEADBEEF}); end
    checks++; if ({o_lk_hit0, o_lk_data0} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL single_fwd got=%h exp=%h", {o_lk_hit0, o_lk_data0}, {1'b1, 32'hDEADBEEF}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (rf_arr[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_regfile got=%h exp=deadbeef", rf_arr[5]); end
    tick();
  endtask

  task automatic test_fill_stall();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'(k), 32'h11 * k, 1, 0, 0, 0);
      tick();
    end
    drive(1, 9, 32'h99, 1, 0, 0, 0);
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", o_count); end
    checks++; if (o_wb_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", o_wb_ready); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 9, 0, 0);
      checks++; if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 5'(k), 32'h11 * k}) begin failures++; $display("FAIL fill_drain%0d got=%h exp=%h", k, {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 5'(k), 32'h11 * k}); end
      checks++; if (o_lk_hit0 !== 1'b0) begin failures++; $display("FAIL fill_5th_dropped%0d got=%b exp=0", k, o_lk_hit0); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b exp=1", o_empty); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (rf_arr[k] !== 32'h11 * k) begin failures++; $display("FAIL fill_regfile%0d got=%h exp=%h", k, rf_arr[k], 32'h11 * k); end
    end
    tick();
  endtask

  task automatic test_forward_priority();
    drive(1, 7, 32'hA, 1, 0, 0, 0); tick();
    drive(1, 7, 32'hB, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 7, 8, 0);
    checks++; if ({o_lk_hit0, o_lk_data0} !== {1'b1, 32'hB}) begin failures++; $display("FAIL fwd_newest got=%h exp=%h", {o_lk_hit0, o_lk_data0}, {1'b1, 32'hB}); end
    checks++; if ({o_lk_hit1, o_lk_data1} !== 33'd0) begin failures++; $display("FAIL fwd_miss got=%h exp=0", {o_lk_hit1, o_lk_data1}); end
    tick();
    drive(0, 0, 0, 0, 7, 8, 0);
    checks++; if ({o_wr_en, o_wr_data, o_lk_hit0, o_lk_data0} !== {1'b1, 32'hA, 1'b1, 32'hB}) begin failures++; $display("FAIL fwd_during_drain got=%h exp=%h", {o_wr_en, o_wr_data, o_lk_hit0, o_lk_data0}, {1'b1, 32'hA, 1'b1, 32'hB}); end
    tick();
    drive(0, 0, 0, 0, 7, 8, 0);
    checks++; if ({o_wr_en, o_lk_hit0, o_lk_data0} !== {1'b1, 1'b1, 32'hB}) begin failures++; $display("FAIL fwd_head_hit got=%h exp=%h", {o_wr_en, o_lk_hit0, o_lk_data0}, {1'b1, 1'b1, 32'hB}); end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 32'h1234, 0, 0, 0, 0);
    checks++; if (o_wb_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b exp=1", o_wb_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if ({o_count, o_wr_en, o_lk_hit0} !== 5'd0) begin failures++; $display("FAIL zero_dropped got=%b exp=0", {o_count, o_wr_en, o_lk_hit0}); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(20 + k), $urandom, 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL rmid_count got=%0d exp=3", o_count); end
    drive(0, 0, 0, 0, 20, 21, 1);
    checks++; if (o_wr_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%b exp=0", o_wr_en); end
    tick();
    drive(0, 0, 0, 0, 20, 21, 0);
    checks++; if ({o_count, o_empty, o_lk_hit0, o_lk_hit1} !== {3'd0, 1'b1, 2'b00}) begin failures++; $display("FAIL rmid_cleared got=%b exp=%b", {o_count, o_empty, o_lk_hit0, o_lk_hit1}, {3'd0, 1'b1, 2'b00}); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0); tick();
    end
    for (int k = 20; k < 23; k++) begin
      checks++; if (rf_arr[k] !== rf_model[k]) begin failures++; $display("FAIL rmid_regfile%0d got=%h exp=%h", k, rf_arr[k], rf_model[k]); end
    end
  endtask

  task automatic test_random();
    logic [108:0] got, exp;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) == 0));
      got = {o_wb_ready, o_wr_en, o_wr_addr, o_wr_data, o_count, o_empty,
             o_lk_hit0, o_lk_data0, o_lk_hit1, o_lk_data1};
      exp = {e_ready, e_wr_en, e_addr, e_data, e_count, e_empty,
             e_hit0, e_d0, e_hit1, e_d1};
      checks++; if (got !== exp) begin failures++; $display("FAIL rand_cycle%0d got=%h exp=%h", c, got, exp); end
      tick();
    end
    for (int c = 0; c < 2 * DEPTH; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL rand_drained got=%b exp=1", o_empty); end
    for (int r = 0; r < 32; r++) begin
      checks++; if (rf_arr[r] !== rf_model[r]) begin failures++; $display("FAIL rand_regfile%0d got=%h exp=%h", r, rf_arr[r], rf_model[r]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int r = 0; r < 32; r++) begin
      rf_model[r] = 32'd0;
      rf_arr[r]   = 32'd0;
    end
    i_rst = 1'b1; i_wb_valid = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_wr_stall = 1'b0; i_lk_addr0 = '0; i_lk_addr1 = '0;
    @(negedge i_clk);
    test_reset();
    test_single_write();
    test_fill_stall();
    test_forward_priority();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
